// File: rtl/digdug_vram_responder.sv
// Responder for the video scan-read ports: owns FG VRAM and the three sprite-attribute
// banks, serves video strobe fetches first and fits CPU accesses into the idle cycles.
module digdug_vram_responder #(
    parameter int FG_AW = 10,
    parameter int SP_AW = 7
) (
    input  logic             CLK48M,
    input  logic             RESET,
    input  logic             FGSCCL,
    input  logic [FG_AW-1:0] FGSCAD,
    output logic [7:0]       FGSCDT,
    input  logic             SPATCL,
    input  logic [SP_AW-1:0] SPATAD,
    output logic [23:0]      SPATDT,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [10:0]      cpu_addr,
    input  logic [7:0]       cpu_wdata,
    output logic             cpu_ack,
    output logic [7:0]       cpu_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic fg_prev, sp_prev;
    logic fg_slot, sp_slot;
    logic fg_slot_d, sp_slot_d;

    logic [1:0] sel;
    logic       tgt_vram, tgt_sp, tgt_unmapped;
    logic       busy, go;

    logic [FG_AW-1:0] vram_addr;
    logic [SP_AW-1:0] sp_addr;
    logic             vram_we;
    logic [2:0]       sp_we;

    logic [7:0]       vram [0:(2**FG_AW)-1];
    logic [7:0]       sp_mem [0:2][0:(2**SP_AW)-1];
    logic [7:0]       vram_q;
    logic [2:0][7:0]  sp_q;

    logic       acc_we, acc_vram, acc_unmapped;
    logic [1:0] acc_sel;
    logic [7:0] rdata_hold;
    logic [7:0] ack_byte;

    assign fg_slot = FGSCCL & ~fg_prev;
    assign sp_slot = SPATCL & ~sp_prev;

    // cpu_addr[9] is a mirror bit in sprite space, so only [8:7] picks the bank.
    assign sel          = cpu_addr[8:7];
    assign tgt_vram     = ~cpu_addr[10];
    assign tgt_unmapped = cpu_addr[10] & (sel == 2'd3);
    assign tgt_sp       = cpu_addr[10] & (sel != 2'd3);

    assign busy = (tgt_vram & fg_slot) | (tgt_sp & sp_slot);
    assign go   = (state == IDLE) & cpu_req & ~busy;

    assign vram_addr = fg_slot ? FGSCAD : cpu_addr[FG_AW-1:0];
    assign sp_addr   = sp_slot ? SPATAD : cpu_addr[SP_AW-1:0];

    // Gating with RESET keeps an uncommitted access from landing while reset is held.
    assign vram_we = go & cpu_we & tgt_vram & ~RESET;
    always_comb begin
        sp_we = 3'b000;
        for (int b = 0; b < 3; b++) begin
            sp_we[b] = go & cpu_we & tgt_sp & (sel == 2'(b)) & ~RESET;
        end
    end

    always_ff @(posedge CLK48M) begin
        if (vram_we) begin
            vram[vram_addr] <= cpu_wdata;
        end
        vram_q <= vram[vram_addr];
        for (int b = 0; b < 3; b++) begin
            if (sp_we[b]) begin
                sp_mem[b][sp_addr] <= cpu_wdata;
            end
            sp_q[b] <= sp_mem[b][sp_addr];
        end
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            fg_prev   <= 1'b0;
            sp_prev   <= 1'b0;
            fg_slot_d <= 1'b0;
            sp_slot_d <= 1'b0;
            FGSCDT    <= 8'h00;
            SPATDT    <= 24'h000000;
        end else begin
            fg_prev   <= FGSCCL;
            sp_prev   <= SPATCL;
            fg_slot_d <= fg_slot;
            sp_slot_d <= sp_slot;
            if (fg_slot_d) begin
                FGSCDT <= vram_q;
            end
            if (sp_slot_d) begin
                SPATDT <= sp_q;
            end
        end
    end

    always_ff @(posedge CLK48M or posedge RESET) begin
        if (RESET) begin
            state        <= IDLE;
            acc_we       <= 1'b0;
            acc_vram     <= 1'b0;
            acc_unmapped <= 1'b0;
            acc_sel      <= 2'd0;
            rdata_hold   <= 8'h00;
        end else begin
            state <= state_nxt;
            if (go) begin
                acc_we       <= cpu_we;
                acc_vram     <= tgt_vram;
                acc_unmapped <= tgt_unmapped;
                acc_sel      <= sel;
            end
            if (state == ACK) begin
                rdata_hold <= ack_byte;
            end
        end
    end

    // RAM read data is valid during ACK because the access edge used the CPU address.
    always_comb begin
        ack_byte = rdata_hold;
        if (!acc_we) begin
            if (acc_unmapped) begin
                ack_byte = 8'hFF;
            end else if (acc_vram) begin
                ack_byte = vram_q;
            end else begin
                case (acc_sel)
                    2'd0:    ack_byte = sp_q[0];
                    2'd1:    ack_byte = sp_q[1];
                    2'd2:    ack_byte = sp_q[2];
                    default: ack_byte = 8'hFF;
                endcase
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cpu_ack   = 1'b0;
        cpu_rdata = rdata_hold;
        case (state)
            IDLE: begin
                if (go) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                cpu_ack   = 1'b1;
                cpu_rdata = ack_byte;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!cpu_req) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_digdug_vram_responder.sv
// Bench for digdug_vram_responder: directed collision/reset scenarios plus random
// CPU and scan traffic checked against an address-map model of the RAM contents.
module tb_digdug_vram_responder;

    logic        CLK48M = 1'b0;
    logic        RESET;
    logic        FGSCCL;
    logic [9:0]  FGSCAD;
    logic [7:0]  FGSCDT;
    logic        SPATCL;
    logic [6:0]  SPATAD;
    logic [23:0] SPATDT;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] vram_m [1024];
    logic [7:0] sp_m [3][128];
    logic [7:0] fg_exp;
    logic [23:0] sp_exp;

    digdug_vram_responder dut (
        .CLK48M    (CLK48M),
        .RESET     (RESET),
        .FGSCCL    (FGSCCL),
        .FGSCAD    (FGSCAD),
        .FGSCDT    (FGSCDT),
        .SPATCL    (SPATCL),
        .SPATAD    (SPATAD),
        .SPATDT    (SPATDT),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata)
    );

    always #5 CLK48M = ~CLK48M;

    task automatic tick();
        @(posedge CLK48M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_rd(input logic [10:0] a);
        logic [1:0] b;
        b = a[8:7];
        if (!a[10]) return vram_m[a[9:0]];
        if (b == 2'd3) return 8'hFF;
        return sp_m[b][a[6:0]];
    endfunction

    task automatic model_wr(input logic [10:0] a, input logic [7:0] d);
        logic [1:0] b;
        b = a[8:7];
        if (!a[10]) vram_m[a[9:0]] = d;
        else if (b != 2'd3) sp_m[b][a[6:0]] = d;
    endtask

    function automatic logic [23:0] sp_row(input logic [6:0] e);
        return {sp_m[2][e], sp_m[1][e], sp_m[0][e]};
    endfunction

    // Full 4-phase CPU transaction; leaves the DUT back in its idle state.
    task automatic cpu_access(input logic we, input logic [10:0] a, input logic [7:0] d,
                              output logic [7:0] rd, output int lat);
        logic got;
        got = 1'b0;
        rd = 8'h00;
        lat = 0;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = d;
        cpu_req = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                got = 1'b1;
                rd = cpu_rdata;
                lat = i;
                break;
            end
        end
        check("cpu_ack_seen", 32'(got), 32'd1);
        cpu_req = 1'b0;
        tick();
        tick();
        if (we) model_wr(a, d);
    endtask

    task automatic fg_scan(input logic [9:0] a);
        FGSCAD = a;
        FGSCCL = 1'b1;
        tick();
        check("fg_before_latency", 32'(FGSCDT), 32'(fg_exp));
        FGSCCL = 1'b0;
        tick();
        fg_exp = vram_m[a];
        check("fg_scan_data", 32'(FGSCDT), 32'(fg_exp));
    endtask

    task automatic sp_scan(input logic [6:0] e);
        SPATAD = e;
        SPATCL = 1'b1;
        tick();
        check("sp_before_latency", 32'(SPATDT), 32'(sp_exp));
        SPATCL = 1'b0;
        tick();
        sp_exp = sp_row(e);
        check("sp_scan_data", 32'(SPATDT), 32'(sp_exp));
    endtask

    // VRAM write requested in the very cycle of an FG slot to the same address.
    task automatic fg_collision(input logic [9:0] a, input logic [7:0] d);
        logic [7:0] old;
        old = vram_m[a];
        FGSCAD = a;
        FGSCCL = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = {1'b0, a};
        cpu_wdata = d;
        cpu_req = 1'b1;
        tick();
        check("coll_ack_deferred", 32'(cpu_ack), 32'd0);
        FGSCCL = 1'b0;
        tick();
        check("coll_ack_late", 32'(cpu_ack), 32'd1);
        fg_exp = old;
        check("coll_fg_old", 32'(FGSCDT), 32'(fg_exp));
        cpu_req = 1'b0;
        tick();
        tick();
        model_wr({1'b0, a}, d);
        fg_scan(a);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] nv;
        logic [10:0] a;
        int lat;
        int acks;

        RESET = 1'b1;
        FGSCCL = 1'b0;
        FGSCAD = '0;
        SPATCL = 1'b0;
        SPATAD = '0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        fg_exp = 8'h00;
        sp_exp = 24'h000000;

        #12;
        check("rst_fgscdt", 32'(FGSCDT), 32'h00);
        check("rst_spatdt", 32'(SPATDT), 32'h000000);
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'h00);
        tick();
        RESET = 1'b0;
        tick();
        tick();
        check("idle_fgscdt", 32'(FGSCDT), 32'h00);
        check("idle_spatdt", 32'(SPATDT), 32'h000000);
        check("idle_ack", 32'(cpu_ack), 32'd0);

        // Populate every mapped byte so later reads have a known reference.
        for (int i = 0; i < 1024; i++) begin
            cpu_access(1'b1, 11'(i), 8'($urandom_range(0, 255)), rd, lat);
        end
        for (int b = 0; b < 3; b++) begin
            for (int e = 0; e < 128; e++) begin
                a = {1'b1, 1'($urandom_range(0, 1)), 2'(b), 7'(e)};
                cpu_access(1'b1, a, 8'($urandom_range(0, 255)), rd, lat);
            end
        end

        cpu_access(1'b1, 11'h155, 8'hA5, rd, lat);
        check("wr_lat", 32'(lat), 32'd1);
        fg_scan(10'h155);
        check("fg_a5", 32'(FGSCDT), 32'hA5);

        cpu_access(1'b1, 11'h405, 8'h11, rd, lat);
        cpu_access(1'b1, 11'h485, 8'h22, rd, lat);
        cpu_access(1'b1, 11'h505, 8'h33, rd, lat);
        sp_scan(7'h05);
        check("sp_332211", 32'(SPATDT), 32'h332211);
        cpu_access(1'b0, 11'h605, 8'h00, rd, lat);
        check("mirror_rd", 32'(rd), 32'h11);
        check("rd_lat", 32'(lat), 32'd1);

        fg_collision(10'h0AA, ~vram_m[10'h0AA]);

        // Both slots plus a bank1 write in one cycle.
        FGSCAD = 10'h2C3;
        SPATAD = 7'h12;
        FGSCCL = 1'b1;
        SPATCL = 1'b1;
        nv = ~sp_m[1][7'h12];
        cpu_we = 1'b1;
        cpu_addr = 11'h492;
        cpu_wdata = nv;
        cpu_req = 1'b1;
        tick();
        check("dual_ack_deferred", 32'(cpu_ack), 32'd0);
        FGSCCL = 1'b0;
        SPATCL = 1'b0;
        tick();
        check("dual_ack_late", 32'(cpu_ack), 32'd1);
        fg_exp = vram_m[10'h2C3];
        sp_exp = sp_row(7'h12);
        check("dual_fg", 32'(FGSCDT), 32'(fg_exp));
        check("dual_sp_old", 32'(SPATDT), 32'(sp_exp));
        cpu_req = 1'b0;
        tick();
        tick();
        model_wr(11'h492, nv);
        sp_scan(7'h12);

        // Request held high: one ack only, unmapped read gives 0xFF.
        cpu_we = 1'b0;
        cpu_addr = 11'h780;
        cpu_req = 1'b1;
        acks = 0;
        rd = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cpu_ack === 1'b1) begin
                acks++;
                rd = cpu_rdata;
            end
        end
        check("hold_one_ack", 32'(acks), 32'd1);
        check("unmapped_rd", 32'(rd), 32'hFF);
        check("hold_rdata_kept", 32'(cpu_rdata), 32'hFF);
        cpu_req = 1'b0;
        tick();
        tick();
        cpu_access(1'b1, 11'h780, 8'h5A, rd, lat);
        check("unmapped_wr_lat", 32'(lat), 32'd1);
        for (int b = 0; b < 3; b++) begin
            a = {2'b10, 2'(b), 7'h00};
            cpu_access(1'b0, a, 8'h00, rd, lat);
            check("unmapped_no_alias", 32'(rd), 32'(model_rd(a)));
        end

        // Reset during a deferred write.
        nv = ~vram_m[10'h0F0];
        FGSCAD = 10'h0F0;
        FGSCCL = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 11'h0F0;
        cpu_wdata = nv;
        cpu_req = 1'b1;
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_ack", 32'(cpu_ack), 32'd0);
        check("midrst_fgscdt", 32'(FGSCDT), 32'h00);
        check("midrst_spatdt", 32'(SPATDT), 32'h000000);
        check("midrst_rdata", 32'(cpu_rdata), 32'h00);
        tick();
        check("rst_hold_ack", 32'(cpu_ack), 32'd0);
        tick();
        cpu_req = 1'b0;
        FGSCCL = 1'b0;
        #2;
        RESET = 1'b0;
        fg_exp = 8'h00;
        sp_exp = 24'h000000;
        tick();
        check("post_rst_ack", 32'(cpu_ack), 32'd0);
        cpu_access(1'b0, 11'h0F0, 8'h00, rd, lat);
        check("no_partial_write", 32'(rd), 32'(model_rd(11'h0F0)));

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: begin
                    cpu_access(1'b1, 11'($urandom_range(0, 2047)), 8'($urandom_range(0, 255)), rd, lat);
                    check("rnd_wr_lat", 32'(lat), 32'd1);
                end
                1: begin
                    a = 11'($urandom_range(0, 2047));
                    cpu_access(1'b0, a, 8'h00, rd, lat);
                    check("rnd_rd", 32'(rd), 32'(model_rd(a)));
                end
                2: fg_scan(10'($urandom_range(0, 1023)));
                3: sp_scan(7'($urandom_range(0, 127)));
                default: fg_collision(10'($urandom_range(0, 1023)), 8'($urandom_range(0, 255)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
